// File: rtl/fp_div_pkg.sv
// Shared definitions for the floating-point divide path: FSM encoding and
// default field widths used by unpack, normalization and the mantissa divider.
package fp_div_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int BIAS_DEF  = 127;
  localparam int STEP_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_e;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter int W     = 24,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     din,
  output logic [CNT_W-1:0] cnt
);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    cnt = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) begin
        cnt = CNT_W'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_div_norm_iter.sv
// Iterative subnormal normalization ahead of the mantissa divider: shifts each
// operand left up to STEP bits per cycle and reports the biased exponent difference.
module fp_div_norm_iter
  import fp_div_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int BIAS  = BIAS_DEF,
  parameter int STEP  = STEP_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W-1:0]        a_exp,
  input  logic [MAN_W-1:0]        a_mant,
  input  logic [EXP_W-1:0]        b_exp,
  input  logic [MAN_W-1:0]        b_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MAN_W:0]          norm_a_mant,
  output logic [MAN_W:0]          norm_b_mant,
  output logic signed [EXP_W+2:0] exp_diff,
  output logic                    a_zero,
  output logic                    b_zero
);

  localparam int MW   = MAN_W + 1;
  localparam int EW   = EXP_W + 3;
  localparam int LZ_W = $clog2(MAN_W + 2);

  norm_state_e          state_q, state_d;
  logic [MW-1:0]        a_mant_q, a_mant_d;
  logic [MW-1:0]        b_mant_q, b_mant_d;
  logic signed [EW-1:0] ea_q, ea_d;
  logic signed [EW-1:0] eb_q, eb_d;
  logic                 a_zero_q, a_zero_d;
  logic                 b_zero_q, b_zero_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;

  logic [LZ_W-1:0]      a_lz, b_lz;
  logic [LZ_W-1:0]      a_sh, b_sh;

  function automatic logic is_done(input logic [MW-1:0] m);
    return m[MW-1] || (m == '0);
  endfunction

  fp_lzc #(.W(MW), .CNT_W(LZ_W)) u_lzc_a (
    .din (a_mant_q),
    .cnt (a_lz)
  );

  fp_lzc #(.W(MW), .CNT_W(LZ_W)) u_lzc_b (
    .din (b_mant_q),
    .cnt (b_lz)
  );

  assign a_sh = (a_lz > LZ_W'(STEP)) ? LZ_W'(STEP) : a_lz;
  assign b_sh = (b_lz > LZ_W'(STEP)) ? LZ_W'(STEP) : b_lz;

  always_comb begin
    state_d  = state_q;
    a_mant_d = a_mant_q;
    b_mant_d = b_mant_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    a_zero_d = a_zero_q;
    b_zero_d = b_zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_mant_d = {a_exp != '0, a_mant};
          b_mant_d = {b_exp != '0, b_mant};
          ea_d     = (a_exp == '0) ? EW'(1) : EW'(a_exp);
          eb_d     = (b_exp == '0) ? EW'(1) : EW'(b_exp);
          a_zero_d = (a_exp == '0) && (a_mant == '0);
          b_zero_d = (b_exp == '0) && (b_mant == '0);
          state_d  = (is_done(a_mant_d) && is_done(b_mant_d)) ? DONE : NORM;
        end
      end
      NORM: begin
        if (!is_done(a_mant_q)) begin
          a_mant_d = a_mant_q << a_sh;
          ea_d     = ea_q - EW'(a_sh);
        end
        if (!is_done(b_mant_q)) begin
          b_mant_d = b_mant_q << b_sh;
          eb_d     = eb_q - EW'(b_sh);
        end
        // Leave on the same edge as the final shift.
        state_d = (is_done(a_mant_d) && is_done(b_mant_d)) ? DONE : NORM;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_mant_q    <= '0;
      b_mant_q    <= '0;
      ea_q        <= '0;
      eb_q        <= '0;
      a_zero_q    <= 1'b0;
      b_zero_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_mant_q    <= a_mant_d;
      b_mant_q    <= b_mant_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      a_zero_q    <= a_zero_d;
      b_zero_q    <= b_zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Exponent difference is only meaningful while a result is presented.
  assign exp_diff    = out_valid_q ? (ea_q - eb_q + EW'(BIAS)) : '0;
  assign norm_a_mant = a_mant_q;
  assign norm_b_mant = b_mant_q;
  assign a_zero      = a_zero_q;
  assign b_zero      = b_zero_q;
  assign out_valid   = out_valid_q;
  assign in_ready    = in_ready_q;

endmodule

// File: tb/tb_fp_div_norm_iter.sv
// Directed bench for fp_div_norm_iter: hand-computed vectors for normal,
// subnormal, zero, backpressure and mid-operation reset cases.
module tb_fp_div_norm_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a_exp = '0;
  logic [22:0] a_mant = '0;
  logic [7:0]  b_exp = '0;
  logic [22:0] b_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] norm_a_mant;
  logic [23:0] norm_b_mant;
  logic signed [10:0] exp_diff;
  logic        a_zero;
  logic        b_zero;

  int checks = 0;
  int failures = 0;

  fp_div_norm_iter #(.EXP_W(8), .MAN_W(23), .BIAS(127), .STEP(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_exp       (a_exp),
    .a_mant      (a_mant),
    .b_exp       (b_exp),
    .b_mant      (b_mant),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .norm_a_mant (norm_a_mant),
    .norm_b_mant (norm_b_mant),
    .exp_diff    (exp_diff),
    .a_zero      (a_zero),
    .b_zero      (b_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)",
             tag, obs, obs, exp_v, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ae, input logic [22:0] am,
                               input logic [7:0] be, input logic [22:0] bm);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    a_exp = ae; a_mant = am; b_exp = be; b_mant = bm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as cycle 1.
  task automatic waitValid(input string tag, input int exp_lat);
    int cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_out_valid"}, out_valid, 1);
  endtask

  task automatic checkOutput(input string tag, input int exp_a, input int exp_b,
                             input int exp_d, input int exp_az, input int exp_bz);
    check({tag, "_norm_a"}, norm_a_mant, exp_a);
    check({tag, "_norm_b"}, norm_b_mant, exp_b);
    check({tag, "_exp_diff"}, exp_diff, exp_d);
    check({tag, "_a_zero"}, a_zero, exp_az);
    check({tag, "_b_zero"}, b_zero, exp_bz);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_after_consume"}, out_valid, 0);
    check({tag, "_ready_after_consume"}, in_ready, 1);
  endtask

  initial begin
    $display("[TB] start");
    #2;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    checkOutput("reset", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", in_ready, 1);

    applyStimulus(8'd130, 23'h000000, 8'd127, 23'h400000);
    waitValid("normal", 1);
    checkOutput("normal", 'h800000, 'hC00000, 130, 0, 0);
    consume("normal");

    applyStimulus(8'd0, 23'h000001, 8'd127, 23'h000000);
    waitValid("deep", 7);
    checkOutput("deep", 'h800000, 'h800000, -22, 0, 0);
    consume("deep");

    applyStimulus(8'd0, 23'h100000, 8'd0, 23'h000800);
    waitValid("both_sub", 4);
    checkOutput("both_sub", 'h800000, 'h800000, 136, 0, 0);
    consume("both_sub");

    applyStimulus(8'd127, 23'h000000, 8'd0, 23'h000000);
    waitValid("b_zero", 1);
    checkOutput("b_zero", 'h800000, 0, 253, 0, 1);
    consume("b_zero");

    // Backpressure with a competing request that must be ignored.
    applyStimulus(8'd0, 23'h000000, 8'd5, 23'h000000);
    waitValid("a_zero", 1);
    checkOutput("a_zero", 0, 'h800000, 123, 1, 0);
    a_exp = 8'd200; a_mant = 23'h000001; b_exp = 8'd0; b_mant = 23'h000003;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      checkOutput("stall", 0, 'h800000, 123, 1, 0);
    end
    in_valid = 1'b0;
    consume("a_zero");

    applyStimulus(8'd0, 23'h000001, 8'd127, 23'h000000);
    @(posedge clk);
    @(posedge clk); #1;
    check("mid_norm_out_valid", out_valid, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    checkOutput("midrst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_release_in_ready", in_ready, 1);

    applyStimulus(8'd140, 23'h000001, 8'd100, 23'h7FFFFF);
    waitValid("after_rst", 1);
    checkOutput("after_rst", 'h800001, 'hFFFFFF, 167, 0, 0);
    consume("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
